// File: rtl/uart_pkg.sv
// uart_pkg: shared types and limits for the UART receive/transmit blocks.
package uart_pkg;
    localparam int MAX_DATA_BITS = 9;
    localparam int MIN_BAUD_DIV  = 4;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_e;
endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period down-counter; o_smp pulses when the count hits 0 while enabled.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int DIV      = 16,
    parameter int LOAD_VAL = 8
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_load,
    input  logic i_clr,
    input  logic i_en,
    output logic o_smp
);
    localparam int W = $clog2(DIV > MIN_BAUD_DIV ? DIV : MIN_BAUD_DIV);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        o_smp = i_en && cnt_q == '0;
        cnt_d = i_load ? W'(LOAD_VAL) : i_clr ? '0 : cnt_q == '0 ? W'(DIV - 1) : cnt_q - 1'b1;
    end

    always_ff @(posedge i_clk) cnt_q <= i_reset ? '0 : cnt_d;
endmodule

// File: rtl/uart_rx_fe.sv
// uart_rx_fe: parametrised UART receiver with parity, framing error and break detection.
// Define UART_RX_FE_SYNC_EN to pass i_rx through a 2-flop synchroniser (+2 cycles latency).
module uart_rx_fe
    import uart_pkg::*;
#(
    parameter int BAUD_DIV  = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_break
);
    localparam int   IW      = $clog2(MAX_DATA_BITS);
    localparam logic HAS_PAR = PARITY != int'(PARITY_NONE);
    localparam logic ODD     = PARITY == int'(PARITY_ODD);

    rx_state_e            state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                 par_q, par_d, perr_q, perr_d, pbit_q, pbit_d;
    logic                 ferr_q, ferr_d, stop0_q, stop0_d, sidx_q, sidx_d;
    logic                 rx_s, smp, load, clr, run, valid;

`ifdef UART_RX_FE_SYNC_EN
    logic [1:0] sync_q, sync_d;
    always_comb sync_d = {sync_q[0], i_rx};
    always_ff @(posedge i_clk) sync_q <= i_reset ? 2'b11 : sync_d;
    assign rx_s = sync_q[1];
`else
    assign rx_s = i_rx;
`endif

    assign run = state_q != ST_IDLE && state_q != ST_WAIT_IDLE;

    uart_baud_cnt #(.DIV(BAUD_DIV), .LOAD_VAL(BAUD_DIV / 2)) u_baud (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_load (load),
        .i_clr  (clr),
        .i_en   (run),
        .o_smp  (smp)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        perr_d  = perr_q;
        pbit_d  = pbit_q;
        ferr_d  = ferr_q;
        stop0_d = stop0_q;
        sidx_d  = sidx_q;
        data_d  = data_q;
        valid   = 1'b0;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: if (!rx_s) begin
                state_d = ST_START;
                load    = 1'b1;
                idx_d   = '0;
                par_d   = 1'b0;
                perr_d  = 1'b0;
                pbit_d  = 1'b0;
                ferr_d  = 1'b0;
                sidx_d  = 1'b0;
            end
            ST_START: if (smp) state_d = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA: if (smp) begin
                shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                par_d   = par_q ^ rx_s;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IW'(DATA_BITS - 1)) state_d = HAS_PAR ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: if (smp) begin
                pbit_d  = rx_s;
                perr_d  = (par_q ^ rx_s) != ODD;
                state_d = ST_STOP;
            end
            // Frame completes in the cycle of the last stop sample, so outputs are combinational here.
            ST_STOP: if (smp) begin
                ferr_d  = ferr_q | ~rx_s;
                sidx_d  = 1'b1;
                stop0_d = sidx_q ? stop0_q : rx_s;
                if (sidx_q == 1'(STOP_BITS - 1)) begin
                    valid   = 1'b1;
                    data_d  = shift_q;
                    state_d = rx_s ? ST_IDLE : ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: if (rx_s) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        clr = state_d == ST_IDLE || state_d == ST_WAIT_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
            pbit_q  <= 1'b0;
            ferr_q  <= 1'b0;
            stop0_q <= 1'b0;
            sidx_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            par_q   <= par_d;
            perr_q  <= perr_d;
            pbit_q  <= pbit_d;
            ferr_q  <= ferr_d;
            stop0_q <= stop0_d;
            sidx_q  <= sidx_d;
        end
    end

    assign o_valid      = valid;
    assign o_data       = valid ? shift_q : data_q;
    assign o_parity_err = valid & perr_q;
    assign o_frame_err  = valid & ferr_d;
    assign o_break      = valid & ~|shift_q & ~pbit_q & ~stop0_d;
endmodule

// File: tb/tb_uart_rx_fe.sv
// tb_uart_rx_fe: directed frames into five receiver configurations, checked against a frame-level model.
module tb_uart_rx_fe;
    localparam int N = 5;
    localparam int DIVS  [N] = '{4, 4, 4, 16, 5};
    localparam int DBS   [N] = '{8, 8, 8, 8, 6};
    localparam int PARS  [N] = '{0, 1, 0, 0, 2};
    localparam int STOPS [N] = '{1, 1, 2, 1, 1};
`ifdef UART_RX_FE_SYNC_EN
    localparam int SY = 2;
`else
    localparam int SY = 0;
`endif

    typedef struct {
        int         c;
        logic [8:0] d;
        logic       pe, fe, br;
    } ev_t;

    logic       clk, rst;
    logic       rxv [N];
    logic       vld [N];
    logic       pev [N];
    logic       fev [N];
    logic       brv [N];
    logic [8:0] dat [N];
    int         cyc = 0;
    int         checks = 0, errors = 0;
    ev_t        q [N][$];
    logic [8:0] last [N];
    int         rec_c [N];
    logic [8:0] rec_d [N];
    logic       rec_pe [N];
    logic       rec_fe [N];
    logic       rec_br [N];
    int         nval [N];

    for (genvar g = 0; g < N; g++) begin : gi
        logic [DBS[g]-1:0] od;
        uart_rx_fe #(
            .BAUD_DIV(DIVS[g]), .DATA_BITS(DBS[g]), .PARITY(PARS[g]), .STOP_BITS(STOPS[g])
        ) u_dut (
            .i_clk(clk), .i_reset(rst), .i_rx(rxv[g]), .o_data(od), .o_valid(vld[g]),
            .o_parity_err(pev[g]), .o_frame_err(fev[g]), .o_break(brv[g])
        );
        assign dat[g] = 9'(od);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, want);
        end
    endtask

    // Expected result of one frame, derived from the bit-level frame content and the timing rule.
    task automatic push_exp(input int i, input int t0, input logic [8:0] d, input logic pb,
                            input logic s0, input logic s1);
        ev_t        e;
        logic       p;
        logic [8:0] dm;
        p    = PARS[i] != 0;
        dm   = d & ((9'h1 << DBS[i]) - 9'h1);
        e.c  = t0 + 1 + DIVS[i] / 2 + (DBS[i] + int'(p) + STOPS[i]) * DIVS[i] + SY;
        e.d  = dm;
        e.pe = p && ((^dm ^ pb) != (PARS[i] == 2));
        e.fe = !s0 || (STOPS[i] == 2 && !s1);
        e.br = dm == 9'h0 && !(p && pb) && !s0;
        q[i].push_back(e);
    endtask

    task automatic drive(input int i, input logic [15:0] b, input int n);
        for (int k = 0; k < n; k++) begin
            rxv[i] = b[k];
            repeat (DIVS[i]) tick();
        end
    endtask

    task automatic send(input int i, input logic [8:0] d, input logic pb, input logic s0, input logic s1);
        logic [15:0] b;
        int          n;
        b = '0;
        for (int k = 0; k < DBS[i]; k++) b[1+k] = d[k];
        n = 1 + DBS[i];
        if (PARS[i] != 0) begin
            b[n] = pb;
            n++;
        end
        b[n] = s0;
        n++;
        if (STOPS[i] == 2) begin
            b[n] = s1;
            n++;
        end
        push_exp(i, cyc, d, pb, s0, s1);
        drive(i, b, n);
        rxv[i] = 1'b1;
    endtask

    task automatic cmp();
        ev_t e;
        for (int i = 0; i < N; i++) begin
            if (vld[i]) begin
                checks++;
                nval[i]++;
                if (q[i].size() == 0 || q[i][0].c != cyc) begin
                    errors++;
                    $display("FAIL valid%0d: unexpected o_valid at cycle %0d (data %h)", i, cyc, dat[i]);
                end else begin
                    e = q[i].pop_front();
                    if ({dat[i], pev[i], fev[i], brv[i]} != {e.d, e.pe, e.fe, e.br}) begin
                        errors++;
                        $display("FAIL frame%0d: got data=%h pe=%b fe=%b br=%b, expected data=%h pe=%b fe=%b br=%b",
                                 i, dat[i], pev[i], fev[i], brv[i], e.d, e.pe, e.fe, e.br);
                    end
                    last[i]   = e.d;
                    rec_c[i]  = cyc;
                    rec_d[i]  = dat[i];
                    rec_pe[i] = pev[i];
                    rec_fe[i] = fev[i];
                    rec_br[i] = brv[i];
                end
            end else begin
                checks++;
                if (pev[i] || fev[i] || brv[i] || dat[i] != last[i]) begin
                    errors++;
                    $display("FAIL idle%0d: cycle %0d got data=%h flags=%b%b%b, expected data=%h flags=000",
                             i, cyc, dat[i], pev[i], fev[i], brv[i], last[i]);
                end
            end
            if (q[i].size() != 0 && q[i][0].c < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed%0d: no o_valid at cycle %0d, expected data=%h", i, q[i][0].c, q[i][0].d);
                void'(q[i].pop_front());
            end
        end
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                q[i].delete();
                last[i] = '0;
            end
        end
    endtask

    initial begin
        int t0;
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            rxv[i]  = 1'b1;
            last[i] = '0;
            nval[i] = 0;
            rec_c[i] = 0;
        end
        repeat (3) tick();
        fork
            forever begin
                @(negedge clk);
                cmp();
            end
        join_none
        rst = 1'b0;
        tick();
        chk("reset_data", int'(dat[0]), 0);
        chk("reset_valid", int'(vld[0]), 0);
        repeat (5) tick();

        // 8N1 basic frame and its latency
        t0 = cyc;
        send(0, 9'h0A5, 1'b0, 1'b1, 1'b1);
        repeat (8) tick();
        chk("a5_latency", rec_c[0] - t0, 39 + SY);
        chk("a5_data", int'(rec_d[0]), 'hA5);
        chk("a5_flags", int'({rec_pe[0], rec_fe[0], rec_br[0]}), 0);

        // parity: even and odd
        send(1, 9'h003, 1'b1, 1'b1, 1'b1);
        repeat (8) tick();
        chk("even_bad_pe", int'(rec_pe[1]), 1);
        chk("even_bad_data", int'(rec_d[1]), 3);
        send(1, 9'h003, 1'b0, 1'b1, 1'b1);
        repeat (8) tick();
        chk("even_ok_pe", int'(rec_pe[1]), 0);
        t0 = cyc;
        send(4, 9'h02D, 1'b1, 1'b1, 1'b1);
        repeat (8) tick();
        chk("odd_ok_pe", int'(rec_pe[4]), 0);
        chk("odd_latency", rec_c[4] - t0, 43 + SY);
        send(4, 9'h02D, 1'b0, 1'b1, 1'b1);
        send(4, 9'h011, 1'b1, 1'b1, 1'b1);
        repeat (8) tick();
        chk("odd_b2b_data", int'(rec_d[4]), 'h11);

        // one-cycle glitch, then a real frame starting 10 cycles later
        t0 = cyc;
        rxv[3] = 1'b0;
        tick();
        rxv[3] = 1'b1;
        repeat (9) tick();
        send(3, 9'h0C3, 1'b0, 1'b1, 1'b1);
        repeat (12) tick();
        chk("glitch_then_frame", rec_c[3] - t0, 163 + SY);
        chk("glitch_frame_data", int'(rec_d[3]), 'hC3);

        // break: line low for 30 bit-times
        t0 = cyc;
        push_exp(0, t0, 9'h000, 1'b0, 1'b0, 1'b0);
        rxv[0] = 1'b0;
        repeat (30 * 4) tick();
        rxv[0] = 1'b1;
        chk("break_flag", int'(rec_br[0]), 1);
        chk("break_fe", int'(rec_fe[0]), 1);
        chk("break_data", int'(rec_d[0]), 0);
        repeat (4) tick();
        send(0, 9'h055, 1'b0, 1'b1, 1'b1);
        repeat (8) tick();
        chk("after_break", int'(rec_d[0]), 'h55);
        chk("after_break_brk", int'(rec_br[0]), 0);
        send(0, 9'h03C, 1'b0, 1'b1, 1'b1);
        send(0, 9'h0C3, 1'b0, 1'b1, 1'b1);
        repeat (8) tick();

        // two stop bits
        send(2, 9'h05A, 1'b0, 1'b1, 1'b0);
        repeat (8) tick();
        chk("stop2_fe", int'(rec_fe[2]), 1);
        send(2, 9'h011, 1'b0, 1'b1, 1'b1);
        send(2, 9'h022, 1'b0, 1'b1, 1'b1);
        repeat (8) tick();
        chk("b2b_second", int'(rec_d[2]), 'h22);
        send(2, 9'h000, 1'b0, 1'b0, 1'b1);
        repeat (8) tick();
        chk("stop2_break", int'(rec_br[2]), 1);

        // reset in the middle of the data bits
        drive(0, 16'b1100, 4);
        rst = 1'b1;
        rxv[0] = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) chk("midreset_data", int'(dat[i]), 0);
        repeat (20) tick();
        t0 = cyc;
        send(0, 9'h07E, 1'b0, 1'b1, 1'b1);
        repeat (8) tick();
        chk("after_reset", int'(rec_d[0]), 'h7E);
        chk("after_reset_latency", rec_c[0] - t0, 39 + SY);

        repeat (20) tick();
        chk("count0", nval[0], 6);
        chk("count1", nval[1], 2);
        chk("count2", nval[2], 4);
        chk("count3", nval[3], 1);
        chk("count4", nval[4], 3);
        for (int i = 0; i < N; i++) chk("pending", q[i].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
